// File: rtl/display_pkg.sv
// display_pkg
// Shared constants for the six-digit seven-segment scan logic:
//   N_DIGITS  - number of digit positions on the display
//   SEL_NONE  - digit-select code that enables no digit
//   SEG_OFF   - active-low segment pattern with every segment dark
//   SEG_HEX   - active-low {dp,g,f,e,d,c,b,a} codes for hex 0..F, dp off
//   scan_state_t - scan FSM states
package display_pkg;

  localparam int N_DIGITS = 6;

  localparam logic [2:0] SEL_NONE = 3'b111;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  // Entry n of the packed array is the pattern for nibble value n.
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E D C
    8'h83, 8'h88, 8'h90, 8'h80,   // B A 9 8
    8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
    8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_hex_encoder.sv
// seg_hex_encoder
// Combinational hex-to-seven-segment encoder with decimal point.
// Ports:
//   nibble  in  4  hex value to display
//   dp      in  1  decimal point, 1 = lit
//   seg     out 8  active-low segments {dp,g,f,e,d,c,b,a}
module seg_hex_encoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] base_code;

  assign base_code = SEG_HEX[nibble];

  // Table codes all have the dp segment dark; a lit dp pulls bit 7 low.
  assign seg = {base_code[7] & ~dp, base_code[6:0]};

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for a six-digit seven-segment display.
// A loaded word waits in a pending register and is copied to the active
// register only at the frame boundary, so a frame never mixes two words.
// Each digit slot starts with a dead-time blank to suppress ghosting.
// Parameters:
//   SCAN_DIV   clock cycles per digit slot
//   BLANK_CYC  dead-time cycles at the start of each slot (1..SCAN_DIV-1)
// Ports:
//   clk         in  1   system clock
//   rst         in  1   asynchronous active-high reset
//   load        in  1   capture strobe for data_in/dp_in/en_in
//   data_in     in  24  six hex nibbles, digit0 in [3:0]
//   dp_in       in  6   per-digit decimal point, 1 = lit
//   en_in       in  6   per-digit enable, 0 = digit stays dark
//   bit_disp    out 3   digit index 0..5, 3'b111 = none selected
//   seg_data    out 8   active-low segments {dp,g,f,e,d,c,b,a}
//   pending     out 1   a loaded word is waiting for the frame boundary
//   frame_done  out 1   one-cycle pulse when a pending word is committed
module seg_scan_ctrl
  import display_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] data_in,
  input  logic [5:0]  dp_in,
  input  logic [5:0]  en_in,
  output logic [2:0]  bit_disp,
  output logic [7:0]  seg_data,
  output logic        pending,
  output logic        frame_done
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - BLANK_CYC - 1);
  localparam logic [2:0]       IDX_LAST   = 3'(N_DIGITS - 1);

  scan_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;

  logic [23:0] pend_data_reg, pend_data_next;
  logic [5:0]  pend_dp_reg, pend_dp_next;
  logic [5:0]  pend_en_reg, pend_en_next;
  logic        pending_reg, pending_next;

  logic [23:0] act_data_reg, act_data_next;
  logic [5:0]  act_dp_reg, act_dp_next;
  logic [5:0]  act_en_reg, act_en_next;

  logic        frame_done_reg, frame_done_next;
  logic [2:0]  bit_disp_reg, bit_disp_next;
  logic [7:0]  seg_data_reg, seg_data_next;

  logic        commit;
  logic [3:0]  digit_nib [N_DIGITS];
  logic [3:0]  cur_nib;
  logic        cur_dp;
  logic [7:0]  show_seg;

  // Split the active word into per-digit nibbles.
  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_nib
      assign digit_nib[gi] = act_data_reg[gi*4 +: 4];
    end
  endgenerate

  assign cur_nib = digit_nib[idx_reg];
  assign cur_dp  = act_dp_reg[idx_reg];

  seg_hex_encoder u_enc (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .seg    (show_seg)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    idx_next   = idx_reg;
    commit     = 1'b0;

    case (state_reg)
      ST_BLANK: begin
        if (cnt_reg == BLANK_LAST) begin
          state_next = ST_SHOW;
          cnt_next   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_reg == SHOW_LAST) begin
          state_next = ST_BLANK;
          cnt_next   = '0;
          if (idx_reg == IDX_LAST) begin
            // Frame boundary: the only point where the active word changes.
            idx_next = '0;
            commit   = pending_reg;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
      default: begin
        state_next = ST_BLANK;
        cnt_next   = '0;
      end
    endcase

    // Commit reads the pending registers before a same-cycle load replaces
    // them, so the new word simply becomes the next pending word.
    act_data_next = commit ? pend_data_reg : act_data_reg;
    act_dp_next   = commit ? pend_dp_reg   : act_dp_reg;
    act_en_next   = commit ? pend_en_reg   : act_en_reg;

    pend_data_next = load ? data_in : pend_data_reg;
    pend_dp_next   = load ? dp_in   : pend_dp_reg;
    pend_en_next   = load ? en_in   : pend_en_reg;
    pending_next   = load | (pending_reg & ~commit);

    frame_done_next = commit;

    // Outputs follow the next state so select and segments switch together.
    // idx and the active word never change on an edge that enters SHOW.
    if (state_next == ST_SHOW && act_en_reg[idx_reg]) begin
      bit_disp_next = idx_reg;
      seg_data_next = show_seg;
    end else begin
      bit_disp_next = SEL_NONE;
      seg_data_next = SEG_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_BLANK;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      pend_data_reg  <= '0;
      pend_dp_reg    <= '0;
      pend_en_reg    <= '0;
      pending_reg    <= 1'b0;
      act_data_reg   <= '0;
      act_dp_reg     <= '0;
      act_en_reg     <= '0;
      frame_done_reg <= 1'b0;
      bit_disp_reg   <= SEL_NONE;
      seg_data_reg   <= SEG_OFF;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      pend_data_reg  <= pend_data_next;
      pend_dp_reg    <= pend_dp_next;
      pend_en_reg    <= pend_en_next;
      pending_reg    <= pending_next;
      act_data_reg   <= act_data_next;
      act_dp_reg     <= act_dp_next;
      act_en_reg     <= act_en_next;
      frame_done_reg <= frame_done_next;
      bit_disp_reg   <= bit_disp_next;
      seg_data_reg   <= seg_data_next;
    end
  end

  assign bit_disp   = bit_disp_reg;
  assign seg_data   = seg_data_reg;
  assign pending    = pending_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
// Scoreboard bench for seg_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2.
// A reference model derives every expected output from the cycle count
// since reset (slot = cycle/SCAN_DIV mod 6, position = cycle mod SCAN_DIV)
// plus the pending/active words, pushes it into a queue on each rising edge,
// and a monitor pops and compares on the falling edge.
module tb_seg_scan_ctrl;

  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int ND    = 6;
  localparam int FRAME = SD * ND;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [23:0] data_in = '0;
  logic [5:0]  dp_in = '0;
  logic [5:0]  en_in = '0;
  logic [2:0]  bit_disp;
  logic [7:0]  seg_data;
  logic        pending;
  logic        frame_done;

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .en_in      (en_in),
    .bit_disp   (bit_disp),
    .seg_data   (seg_data),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] seg;
    logic       pend;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic [23:0] m_pdata = '0, m_adata = '0;
  logic [5:0]  m_pdp = '0, m_pen = '0, m_adp = '0, m_aen = '0;
  logic        m_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // Reference model: one expectation per rising edge.
  always @(posedge clk) begin : model
    exp_t e;
    logic fd;
    int   slot, pos;
    e.sel = 3'b111; e.seg = 8'hFF; e.pend = 1'b0; e.fd = 1'b0;
    if (rst) begin
      cyc = 0; m_pend = 1'b0;
      m_adata = '0; m_adp = '0; m_aen = '0;
    end else begin
      cyc++;
      fd = (cyc % FRAME == 0) && m_pend;
      if (fd) begin
        m_adata = m_pdata; m_adp = m_pdp; m_aen = m_pen; m_pend = 1'b0;
      end
      if (load) begin
        m_pdata = data_in; m_pdp = dp_in; m_pen = en_in; m_pend = 1'b1;
      end
      slot = (cyc / SD) % ND;
      pos  = cyc % SD;
      e.pend = m_pend;
      e.fd   = fd;
      if (pos >= BC && m_aen[slot]) begin
        e.sel = 3'(slot);
        e.seg = seg_tab[m_adata[slot*4 +: 4]] & (m_adp[slot] ? 8'h7F : 8'hFF);
      end
    end
    exp_q.push_back(e);
  end

  // Monitor: compare the registered outputs half a cycle after each edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("bit_disp", 32'(bit_disp), 32'(e.sel));
      chk("seg_data", 32'(seg_data), 32'(e.seg));
      chk("pending", 32'(pending), 32'(e.pend));
      chk("frame_done", 32'(frame_done), 32'(e.fd));
      $display("cyc=%0d sel=%0d seg=%02h pend=%0b fd=%0b", cyc, bit_disp, seg_data, pending, frame_done);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a load for the next edge, starting at the current falling edge.
  task automatic load_now(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] en);
    load = 1'b1; data_in = d; dp_in = dp; en_in = en;
    @(negedge clk);
    load = 1'b0;
    data_in = 24'($urandom); dp_in = 6'($urandom); en_in = 6'($urandom);
  endtask

  task automatic do_load(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] en);
    @(negedge clk);
    load_now(d, dp, en);
  endtask

  // Wait (bounded) for a falling edge where the frame position equals target.
  task automatic wait_pos(input int target);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (cyc % FRAME == target) return;
      @(negedge clk);
    end
    chk("wait_pos_timeout", 32'(cyc % FRAME), 32'(target));
  endtask

  initial begin : stim
    int fd_cnt;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // First frame after reset: dark, nothing pending.
    tick(FRAME + 4);

    // Plain digits 0..5 on all slots.
    do_load(24'h543210, 6'h00, 6'h3F);
    tick(2 * FRAME);

    // Two loads in one frame: last one wins, one commit.
    wait_pos(5);
    load_now(24'h111111, 6'h00, 6'h3F);
    tick(10);
    fd_cnt = 0;
    do_load(24'h222222, 6'h00, 6'h3F);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
    end
    chk("frame_done_count", 32'(fd_cnt), 32'd1);

    // Load on the commit edge: old pending commits, new one stays pending.
    wait_pos(10);
    load_now(24'h333333, 6'h00, 6'h3F);
    wait_pos(FRAME - 1);
    load_now(24'h444444, 6'h3F, 6'h3F);
    chk("pending_after_commit_load", 32'(pending), 32'd1);
    tick(2 * FRAME + 4);

    // Sparse enables with a decimal point.
    do_load(24'hFEDCBA, 6'b000001, 6'b000101);
    tick(2 * FRAME);

    // Reset during slot-3 SHOW with a word pending.
    wait_pos(3);
    load_now(24'h777777, 6'h00, 6'h3F);
    wait_pos(3 * SD + 3);
    chk("pending_before_rst", 32'(pending), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_bit_disp", 32'(bit_disp), 32'd7);
    chk("rst_seg_data", 32'(seg_data), 32'hFF);
    chk("rst_pending", 32'(pending), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    tick(2 * FRAME);

    // Random loads at random times, including collisions with commits.
    for (int i = 0; i < 25; i++) begin
      tick($urandom_range(1, 40));
      do_load(24'($urandom), 6'($urandom), 6'($urandom));
    end
    tick(2 * FRAME + 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the six-digit seven-segment display. Captures a six-nibble display word plus decimal-point and digit-enable masks through a load strobe. Commits the captured word only at frame boundaries so the display never shows a torn update. Drives the 3-bit digit index consumed by the digit-select decoder and the matching active-low segment pattern, with a dead-time blank between digits to suppress ghosting.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot; 1 ms at 50 MHz.
- BLANK_CYC, 500: dead-time cycles at the start of each slot; legal range is 1 ≤ BLANK_CYC < SCAN_DIV.
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- load  in  1  one-cycle strobe; captures data_in, dp_in and en_in into the pending register.
- data_in  in  24  six hex nibbles; digit0 = [3:0], digit5 = [23:20].
- dp_in  in  6  decimal point per digit; 1 = lit.
- en_in  in  6  digit enable; 0 = digit blank for its slot.
- bit_disp  out  3  digit index 0..5 to the select decoder; 3'b111 = no digit selected.
- seg_data  out  8  active-low segments {dp,g,f,e,d,c,b,a}; 8'hFF = all off.
- pending  out  1  high while a loaded word awaits commit.
- frame_done  out  1  one-cycle pulse when a pending word is committed.

## Operation
- FSM has two states.
  - BLANK: bit_disp = 3'b111, seg_data = 8'hFF, runs BLANK_CYC cycles, then goes to SHOW.
  - SHOW: runs SCAN_DIV−BLANK_CYC cycles, then goes to BLANK and advances idx.
  - If the digit is enabled, SHOW drives bit_disp = idx and seg_data = hex code of the active nibble, with bit7 cleared when dp is set.
  - If the digit is disabled (en = 0), SHOW keeps bit_disp = 3'b111 and seg_data = 8'hFF.
- idx counts 0→5 and wraps to 0. Wrap is the frame boundary.
- Commit happens at wrap, when pending = 1:
  - active registers ← pending registers;
  - pending clears;
  - frame_done pulses for 1 cycle.
- Segment codes for 0–F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Load while pending = 1 overwrites the pending word; the last load wins.
- Load in the same cycle as a commit:
  - the commit uses the pre-load pending word;
  - the new word enters the pending register;
  - pending stays 1.
- Input changes without load have no effect.
- Reset state:
  - state BLANK, idx 0, slot counter 0;
  - active data, dp and en all 0, so the display stays dark until the first commit;
  - pending 0, frame_done 0;
  - bit_disp 3'b111, seg_data 8'hFF.
- Reset asserted mid-frame returns to the reset state immediately; any pending word is lost.

## Timing
- All outputs are registered and change on the rising clk edge after the state/counter update.
- One slot is SCAN_DIV cycles; one frame is 6×SCAN_DIV cycles.
- After reset release, slot 0 BLANK starts on the first clk edge.
- pending rises the cycle after load.
- Commit occurs on the edge that ends slot-5 SHOW. On that edge:
  - frame_done is high for that one cycle;
  - the new word first appears on seg_data BLANK_CYC cycles later, at the start of slot-0 SHOW.
- Worst-case load-to-display latency: 6×SCAN_DIV + BLANK_CYC cycles.
- bit_disp and seg_data always switch on the same edge; a digit index and a non-FF pattern never overlap across a slot boundary.

## Structure
- Package display_pkg holds:
  - N_DIGITS = 6;
  - SEL_NONE = 3'b111;
  - SEG_OFF = 8'hFF;
  - the 16-entry hex segment constant table.
- Sub-module seg_hex_encoder: combinational, 4-bit nibble + dp → 8-bit active-low pattern.
- The top module holds the FSM, slot counter, idx, and the pending and active registers.

## Test plan
Bench uses SCAN_DIV=8, BLANK_CYC=2.
- Reset held, then released → bit_disp=7, seg_data=FF, pending=0 throughout the first frame.
- Load data_in=24'h543210, en_in=6'h3F, dp_in=0 → frame_done one cycle at the slot-5 end; next frame slots 0..5 show C0 F9 A4 B0 99 92; each slot has 2 cycles of 7/FF, then 6 cycles of idx/code.
- Two loads in one frame, 24'h111111 then 24'h222222 → only 222222 (A4) is displayed; exactly one frame_done.
- Load in the same cycle as a commit → the old pending word is displayed for the next frame, pending stays 1, and the new word commits one frame later.
- en_in=6'b000101, dp_in=6'b000001, data_in=24'hFEDCBA → slot0 = 08 (A with dp), slot2 = C6 (C), all other slots 7/FF.
- rst pulse during slot 3 SHOW with a pending word → outputs 7/FF immediately, pending=0, the old active word is not redisplayed, and scanning restarts at slot 0.
